alu_issue_decoder: RTL and testbench

//  Registered ALU-control decode/issue stage with valid/ready handshakes on both sides. Maps
//  alu_op/opcode/funct3/funct7 to a CTRL_W-bit ALU control word. Resolves all six branch

---
 rtl/alu_issue_decoder.sv | 90 +++++++++
 tb/tb_alu_issue_decoder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_decoder.sv
// alu_issue_decoder: registered ALU-control decode/issue stage with MUL/DIV throttle; RV32M_EN enables M-extension decode
module alu_issue_decoder #(
  parameter int CTRL_W  = 5,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 34
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        alu_op,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alu_control,
  output logic              cmp_invert,
  output logic              multicycle,
  output logic              illegal
);
  localparam int MAX_LAT = MUL_LAT > DIV_LAT ? MUL_LAT : DIV_LAT;
  localparam int BW = $clog2(MAX_LAT + 1);
  logic [BW-1:0] busy;
  logic [4:0] ctrl;
  logic inv, mc, ill;
  function automatic logic [4:0] base_op(input logic [2:0] f);
    return f == 3'd0 ? 5'd0 : f < 3'd6 ? {2'b00, f} + 5'd1 : {2'b00, f} + 5'd2;
  endfunction
  always_comb begin
    ctrl = 5'd0;
    inv = 1'b0;
    mc = 1'b0;
    ill = 1'b0;
    if (alu_op == 2'b01) ctrl = 5'd1;
    else if (alu_op == 2'b11) ill = 1'b1;
    else if (alu_op == 2'b10)
      case (opcode)
        7'b0110011:
          if (funct7 == 7'b0000000) ctrl = base_op(funct3);
          else if (funct7 == 7'b0100000 && funct3 == 3'b000) ctrl = 5'd1;
          else if (funct7 == 7'b0100000 && funct3 == 3'b101) ctrl = 5'd7;
`ifdef RV32M_EN
          else if (funct7 == 7'b0000001) begin
            ctrl = {2'b10, funct3};
            mc = 1'b1;
          end
`endif
          else ill = 1'b1;
        7'b0010011:
          if (funct3 == 3'b001 && funct7 != 7'b0000000) ill = 1'b1;
          else if (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000) ill = 1'b1;
          else ctrl = (funct3 == 3'b101 && funct7[5]) ? 5'd7 : base_op(funct3);
        7'b0000011, 7'b0100011, 7'b1100111, 7'b1101111, 7'b0010111: ctrl = 5'd0;
        7'b0110111: ctrl = 5'd10;
        7'b1100011:
          if (funct3[2:1] == 2'b01) ill = 1'b1;
          else begin
            ctrl = funct3[2] ? (funct3[1] ? 5'd4 : 5'd3) : 5'd1;
            inv = funct3[0];
          end
        default: ill = 1'b1;
      endcase
  end
  assign in_ready = !flush && busy == '0 && (!out_valid || out_ready);
  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      alu_control <= '0;
      cmp_invert <= 1'b0;
      multicycle <= 1'b0;
      illegal <= 1'b0;
      busy <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      busy <= '0;
    end else begin
      if (in_valid && in_ready) begin
        out_valid <= 1'b1;
        alu_control <= CTRL_W'(ctrl);
        cmp_invert <= inv;
        multicycle <= mc;
        illegal <= ill;
      end else if (out_ready) out_valid <= 1'b0;
      busy <= (out_valid && out_ready && multicycle) ? (alu_control[2] ? BW'(DIV_LAT - 1) : BW'(MUL_LAT - 1))
            : busy != '0 ? busy - BW'(1) : busy;
    end
  end
endmodule

// File: tb/tb_alu_issue_decoder.sv
// tb_alu_issue_decoder: randomized and directed checks of alu_issue_decoder against a transaction-level model
module tb_alu_issue_decoder;
  localparam int CTRL_W = 5;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 34;
`ifdef RV32M_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif
  logic clk = 1'b0, resetn = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [1:0] alu_op = '0;
  logic [6:0] opcode = '0, funct7 = '0;
  logic [2:0] funct3 = '0;
  logic in_ready, out_valid, cmp_invert, multicycle, illegal;
  logic [CTRL_W-1:0] alu_control;
  int passed = 0, total = 0;
  bit m_valid, m_inv, m_mc, m_ill;
  int m_ctrl, m_busy;
  int opcs[9] = '{'h33, 'h13, 'h03, 'h23, 'h67, 'h6f, 'h17, 'h37, 'h63};
  always #5 clk = ~clk;
  alu_issue_decoder #(.CTRL_W(CTRL_W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .out_valid(out_valid), .out_ready(out_ready), .alu_control(alu_control),
    .cmp_invert(cmp_invert), .multicycle(multicycle), .illegal(illegal)
  );
  function automatic void ref_decode(input logic [1:0] op, input logic [6:0] opc, input logic [2:0] f3,
                                     input logic [6:0] f7, output int c, output bit inv, output bit mc, output bit ill);
    int base[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    c = 0; inv = 0; mc = 0; ill = 0;
    if (op == 1) c = 1;
    else if (op == 3) ill = 1;
    else if (op == 2) begin
      if (opc == 7'h33) begin
        if (f7 == 0) c = base[f3];
        else if (f7 == 7'h20 && f3 == 0) c = 1;
        else if (f7 == 7'h20 && f3 == 5) c = 7;
        else if (f7 == 1 && M_EN) begin c = 16 + int'(f3); mc = 1; end
        else ill = 1;
      end else if (opc == 7'h13) begin
        if (f3 == 1 && f7 != 0) ill = 1;
        else if (f3 == 5 && !(f7 == 0 || f7 == 7'h20)) ill = 1;
        else c = (f3 == 5 && f7 == 7'h20) ? 7 : base[f3];
      end else if (opc inside {7'h03, 7'h23, 7'h67, 7'h6f, 7'h17}) c = 0;
      else if (opc == 7'h37) c = 10;
      else if (opc == 7'h63) begin
        if (f3 == 2 || f3 == 3) ill = 1;
        else begin
          c = f3 < 2 ? 1 : (f3 < 6 ? 3 : 4);
          inv = f3 inside {3'd1, 3'd5, 3'd7};
        end
      end else ill = 1;
    end
    if (ill) begin c = 0; mc = 0; inv = 0; end
  endfunction
  task automatic tick();
    bit rdy, i1, i2, i3;
    int nb, c;
    rdy = !flush && m_busy == 0 && (!m_valid || out_ready);
    if (!resetn) begin
      m_valid = 0; m_ctrl = 0; m_inv = 0; m_mc = 0; m_ill = 0; m_busy = 0;
    end else if (flush) begin
      m_valid = 0; m_busy = 0;
    end else begin
      nb = m_busy > 0 ? m_busy - 1 : 0;
      if (m_valid && out_ready && m_mc) nb = m_ctrl >= 20 ? DIV_LAT - 1 : MUL_LAT - 1;
      if (in_valid && rdy) begin
        ref_decode(alu_op, opcode, funct3, funct7, c, i1, i2, i3);
        m_valid = 1; m_ctrl = c; m_inv = i1; m_mc = i2; m_ill = i3;
      end else if (out_ready) m_valid = 0;
      m_busy = nb;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input bit v, input logic [1:0] op, input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
    in_valid = v; alu_op = op; opcode = opc; funct3 = f3; funct7 = f7;
    #1;
  endtask
  task automatic test_reset();
    resetn = 0; flush = 0; in_valid = 0; out_ready = 1;
    tick(); tick();
    total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else passed++;
    total++; if (alu_control !== '0) $display("FAIL reset_ctrl: got %0d want 0", alu_control); else passed++;
    total++; if ({cmp_invert, multicycle, illegal} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {cmp_invert, multicycle, illegal}); else passed++;
    resetn = 1;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
  endtask
  task automatic test_add();
    out_ready = 1;
    drive(1, 2, 7'h33, 3'd0, 7'h00);
    tick();
    drive(0, 0, 0, 0, 0);
    total++; if (out_valid !== 1'b1 || alu_control !== 5'd0 || illegal !== 1'b0)
      $display("FAIL add: got v=%b ctrl=%0d ill=%b want v=1 ctrl=0 ill=0", out_valid, alu_control, illegal); else passed++;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL add_drain: got %b want 0", out_valid); else passed++;
  endtask
  task automatic test_branch();
    out_ready = 1;
    drive(1, 2, 7'h63, 3'd7, 7'h00);
    tick();
    drive(1, 2, 7'h63, 3'd4, 7'h00);
    total++; if (out_valid !== 1'b1 || alu_control !== 5'd4 || cmp_invert !== 1'b1)
      $display("FAIL bgeu: got v=%b ctrl=%0d inv=%b want v=1 ctrl=4 inv=1", out_valid, alu_control, cmp_invert); else passed++;
    tick();
    drive(0, 0, 0, 0, 0);
    total++; if (out_valid !== 1'b1 || alu_control !== 5'd3 || cmp_invert !== 1'b0)
      $display("FAIL blt: got v=%b ctrl=%0d inv=%b want v=1 ctrl=3 inv=0", out_valid, alu_control, cmp_invert); else passed++;
    tick();
  endtask
  task automatic test_back_to_back_hold();
    out_ready = 0;
    drive(1, 2, 7'h33, 3'd4, 7'h00);
    tick();
    drive(1, 2, 7'h33, 3'd5, 7'h20);
    for (int i = 0; i < 3; i++) begin
      total++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || alu_control !== 5'd5)
        $display("FAIL hold_%0d: got rdy=%b v=%b ctrl=%0d want rdy=0 v=1 ctrl=5", i, in_ready, out_valid, alu_control); else passed++;
      tick();
    end
    out_ready = 1;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL hold_release: got %b want 1", in_ready); else passed++;
    tick();
    drive(0, 0, 0, 0, 0);
    total++; if (out_valid !== 1'b1 || alu_control !== 5'd7)
      $display("FAIL hold_second: got v=%b ctrl=%0d want v=1 ctrl=7", out_valid, alu_control); else passed++;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL hold_drain: got %b want 0", out_valid); else passed++;
  endtask
  task automatic test_div();
    out_ready = 1;
    drive(1, 2, 7'h33, 3'd4, 7'h01);
    tick();
    drive(0, 0, 0, 0, 0);
`ifdef RV32M_EN
    total++; if (out_valid !== 1'b1 || alu_control !== 5'd20 || multicycle !== 1'b1)
      $display("FAIL div: got v=%b ctrl=%0d mc=%b want v=1 ctrl=20 mc=1", out_valid, alu_control, multicycle); else passed++;
    tick();
    drive(1, 2, 7'h33, 3'd0, 7'h00);
    for (int i = 0; i < DIV_LAT - 1; i++) begin
      total++; if (in_ready !== 1'b0) $display("FAIL div_stall_%0d: got %b want 0", i, in_ready); else passed++;
      tick();
    end
    total++; if (in_ready !== 1'b1) $display("FAIL div_resume: got %b want 1", in_ready); else passed++;
    tick();
    drive(0, 0, 0, 0, 0);
    total++; if (out_valid !== 1'b1 || alu_control !== 5'd0 || multicycle !== 1'b0)
      $display("FAIL div_next_add: got v=%b ctrl=%0d mc=%b want v=1 ctrl=0 mc=0", out_valid, alu_control, multicycle); else passed++;
`else
    total++; if (out_valid !== 1'b1 || illegal !== 1'b1 || alu_control !== 5'd0 || multicycle !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL div_illegal: got v=%b ill=%b ctrl=%0d mc=%b rdy=%b want 1 1 0 0 1", out_valid, illegal, alu_control, multicycle, in_ready); else passed++;
`endif
    tick();
  endtask
  task automatic test_flush();
    out_ready = 1;
    drive(1, 2, 7'h33, 3'd0, 7'h00);
    flush = 1;
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready: got %b want 0", in_ready); else passed++;
    tick();
    flush = 0;
    drive(0, 0, 0, 0, 0);
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flush_drop: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); else passed++;
`ifdef RV32M_EN
    drive(1, 2, 7'h33, 3'd4, 7'h01);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    repeat (DIV_LAT - 11) tick();
    total++; if (in_ready !== 1'b0) $display("FAIL flush_busy_pre: got %b want 0", in_ready); else passed++;
    drive(1, 2, 7'h33, 3'd0, 7'h00);
    flush = 1;
    tick();
    flush = 0;
    drive(0, 0, 0, 0, 0);
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flush_busy: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); else passed++;
`endif
  endtask
  task automatic test_illegal();
    logic [1:0] ops[3] = '{2'd3, 2'd2, 2'd2};
    logic [6:0] opc[3] = '{7'h33, 7'h13, 7'h63};
    logic [2:0] f3s[3] = '{3'd0, 3'd1, 3'd2};
    logic [6:0] f7s[3] = '{7'h00, 7'h20, 7'h00};
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1, ops[i], opc[i], f3s[i], f7s[i]);
      tick();
      drive(0, 0, 0, 0, 0);
      total++; if (out_valid !== 1'b1 || illegal !== 1'b1 || alu_control !== 5'd0 || multicycle !== 1'b0)
        $display("FAIL illegal_%0d: got v=%b ill=%b ctrl=%0d mc=%b want 1 1 0 0", i, out_valid, illegal, alu_control, multicycle); else passed++;
      tick();
    end
  endtask
  task automatic test_reset_mid();
    out_ready = 1;
    drive(1, 2, 7'h33, 3'd5, 7'h01);
    tick();
    drive(0, 0, 0, 0, 0);
    repeat (4) tick();
    resetn = 0;
    tick();
    resetn = 1;
    #1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || alu_control !== 5'd0 || {cmp_invert, multicycle, illegal} !== 3'b000)
      $display("FAIL reset_mid: got rdy=%b v=%b ctrl=%0d flags=%b want 1 0 0 000", in_ready, out_valid, alu_control, {cmp_invert, multicycle, illegal}); else passed++;
  endtask
  task automatic test_random();
    bit rdy;
    for (int n = 0; n < 700; n++) begin
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 29) == 0;
      alu_op = $urandom_range(0, 7) < 5 ? 2'd2 : 2'($urandom_range(0, 3));
      opcode = $urandom_range(0, 9) == 0 ? 7'($urandom) : 7'(opcs[$urandom_range(0, 8)]);
      funct3 = 3'($urandom);
      case ($urandom_range(0, 3))
        0: funct7 = 7'h00;
        1: funct7 = 7'h20;
        2: funct7 = 7'h01;
        default: funct7 = 7'($urandom);
      endcase
      #1;
      rdy = !flush && m_busy == 0 && (!m_valid || out_ready);
      total++; if (in_ready !== rdy || out_valid !== m_valid)
        $display("FAIL rand_hs_%0d: got rdy=%b v=%b want rdy=%b v=%b", n, in_ready, out_valid, rdy, m_valid); else passed++;
      if (m_valid) begin
        total++; if (alu_control !== CTRL_W'(m_ctrl) || cmp_invert !== m_inv || multicycle !== m_mc || illegal !== m_ill)
          $display("FAIL rand_out_%0d: got ctrl=%0d inv=%b mc=%b ill=%b want ctrl=%0d inv=%b mc=%b ill=%b",
                   n, alu_control, cmp_invert, multicycle, illegal, m_ctrl, m_inv, m_mc, m_ill); else passed++;
      end
      tick();
    end
    in_valid = 0;
    flush = 0;
  endtask
  initial begin
    test_reset();
    test_add();
    test_branch();
    test_back_to_back_hold();
    test_div();
    test_flush();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
